// File: rtl/fm_radio_enable_seq.sv
// Reset/enable sequencer for the FM radio IP with packet-aligned gating of its AXI-Stream output.
// Optional beat counter on pass_cnt when FM_RADIO_SEQ_PASS_CNT_EN is defined.
module fm_radio_enable_seq #(
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned RST_CYCLES   = 16,
   parameter int unsigned WARMUP_BEATS = 1024
) (
   input  logic              ACLK,
   input  logic              ARESETN,
   input  logic [7:0]        cfg_enable,
   output logic              radio_rst_n,
   output logic              radio_en,
   input  logic [DATA_W-1:0] s_axis_tdata,
   input  logic              s_axis_tvalid,
   input  logic              s_axis_tlast,
   output logic              s_axis_tready,
   output logic [DATA_W-1:0] m_axis_tdata,
   output logic              m_axis_tvalid,
   output logic              m_axis_tlast,
   input  logic              m_axis_tready,
   output logic [2:0]        seq_state,
   output logic [31:0]       pass_cnt
);

   localparam int unsigned TMR_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam int unsigned WCNT_W = $clog2(WARMUP_BEATS + 1);
   localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(RST_CYCLES - 1);
   localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(WARMUP_BEATS);

   typedef enum logic [2:0] {
      ST_OFF    = 3'd0,
      ST_RESET  = 3'd1,
      ST_WARMUP = 3'd2,
      ST_RUN    = 3'd3,
      ST_DRAIN  = 3'd4
   } state_e;

   state_e            state_q, state_d;
   logic [TMR_W-1:0]  timer_q, timer_d;
   logic [WCNT_W-1:0] wcnt_q, wcnt_d, wcnt_inc;
   logic              in_pkt_q, in_pkt_d;
   logic              radio_rst_n_q, radio_rst_n_d;
   logic              radio_en_q, radio_en_d;

   logic cfg_run, cfg_force, passthru, s_hs, m_hs;
   logic unused_cfg;

   assign cfg_run    = cfg_enable[0];
   assign cfg_force  = cfg_enable[1];
   assign unused_cfg = ^cfg_enable[7:2];

   // Zero-latency passthrough in RUN/DRAIN; WARMUP sinks and discards beats.
   assign passthru      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign s_axis_tready = passthru ? m_axis_tready : (state_q == ST_WARMUP);
   assign m_axis_tvalid = passthru & s_axis_tvalid;
   assign m_axis_tlast  = passthru & s_axis_tlast;
   assign m_axis_tdata  = passthru ? s_axis_tdata : '0;

   assign s_hs = s_axis_tvalid & s_axis_tready;
   assign m_hs = m_axis_tvalid & m_axis_tready;

   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      wcnt_d   = wcnt_q;
      in_pkt_d = in_pkt_q;
      wcnt_inc = (wcnt_q >= WCNT_MAX) ? WCNT_MAX : wcnt_q + WCNT_W'(1);

      if (s_hs) begin
         in_pkt_d = ~s_axis_tlast;
      end

      case (state_q)
         ST_OFF: begin
            if (cfg_run) state_d = ST_RESET;
         end
         ST_RESET: begin
            // The radio restarts from reset, so any partial packet is gone.
            in_pkt_d = 1'b0;
            if (timer_q == TMR_LAST) begin
               state_d = cfg_run ? ST_WARMUP : ST_OFF;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         ST_WARMUP: begin
            if (!cfg_run) begin
               state_d = ST_OFF;
            end else begin
               if (s_hs) wcnt_d = wcnt_inc;
               if (s_hs && s_axis_tlast && (wcnt_inc >= WCNT_MAX)) begin
                  state_d = ST_RUN;
               end else if (!s_hs && !in_pkt_q && (wcnt_q >= WCNT_MAX)) begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            // Post-handshake packet state decides: a beat starting a packet now must finish it.
            if (!cfg_run) state_d = in_pkt_d ? ST_DRAIN : ST_OFF;
         end
         ST_DRAIN: begin
            if (s_hs && s_axis_tlast) state_d = ST_OFF;
         end
         default: state_d = ST_OFF;
      endcase

      if (cfg_force) state_d = ST_RESET;

      if (state_d != state_q) begin
         timer_d = '0;
         wcnt_d  = '0;
      end
      if (cfg_force) timer_d = '0;

      radio_rst_n_d = (state_d == ST_WARMUP) || (state_d == ST_RUN) || (state_d == ST_DRAIN);
      radio_en_d    = radio_rst_n_d;
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q       <= ST_OFF;
         timer_q       <= '0;
         wcnt_q        <= '0;
         in_pkt_q      <= 1'b0;
         radio_rst_n_q <= 1'b0;
         radio_en_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         wcnt_q        <= wcnt_d;
         in_pkt_q      <= in_pkt_d;
         radio_rst_n_q <= radio_rst_n_d;
         radio_en_q    <= radio_en_d;
      end
   end

   assign radio_rst_n = radio_rst_n_q;
   assign radio_en    = radio_en_q;
   assign seq_state   = state_q;

`ifdef FM_RADIO_SEQ_PASS_CNT_EN
   logic [31:0] pass_cnt_q, pass_cnt_d;

   // Cleared on RESET entry; a beat forwarded in that same cycle belongs to the old session.
   always_comb begin
      pass_cnt_d = pass_cnt_q;
      if ((state_d == ST_RESET) && (state_q != ST_RESET)) begin
         pass_cnt_d = 32'h0;
      end else if (m_hs) begin
         pass_cnt_d = pass_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         pass_cnt_q <= 32'h0;
      end else begin
         pass_cnt_q <= pass_cnt_d;
      end
   end

   assign pass_cnt = pass_cnt_q;
`else
   logic unused_m_hs;
   assign unused_m_hs = m_hs;
   assign pass_cnt    = 32'h0;
`endif

endmodule

// File: tb/tb_fm_radio_enable_seq.sv
// Directed bench for fm_radio_enable_seq: vector table for sequencing/gating,
// then packet-level sequences for warmup, drain, backpressure, force reset and async reset.
module tb_fm_radio_enable_seq;

   localparam int unsigned DATA_W       = 32;
   localparam int unsigned RST_CYCLES   = 16;
   localparam int unsigned WARMUP_BEATS = 1024;
   localparam int unsigned PKT_LEN      = 64;
   localparam int unsigned FORCE_LEN    = 5;

   localparam logic [2:0] S_OFF    = 3'd0;
   localparam logic [2:0] S_RESET  = 3'd1;
   localparam logic [2:0] S_WARMUP = 3'd2;
   localparam logic [2:0] S_RUN    = 3'd3;
   localparam logic [2:0] S_DRAIN  = 3'd4;

`ifdef FM_RADIO_SEQ_PASS_CNT_EN
   localparam logic [31:0] EXP_PASS_300 = 32'd300;
`else
   localparam logic [31:0] EXP_PASS_300 = 32'd0;
`endif

   logic              ACLK = 1'b0;
   logic              ARESETN;
   logic [7:0]        cfg_enable;
   logic              radio_rst_n, radio_en;
   logic [DATA_W-1:0] s_axis_tdata;
   logic              s_axis_tvalid, s_axis_tlast, s_axis_tready;
   logic [DATA_W-1:0] m_axis_tdata;
   logic              m_axis_tvalid, m_axis_tlast, m_axis_tready;
   logic [2:0]        seq_state;
   logic [31:0]       pass_cnt;

   fm_radio_enable_seq #(
      .DATA_W(DATA_W), .RST_CYCLES(RST_CYCLES), .WARMUP_BEATS(WARMUP_BEATS)
   ) dut (
      .ACLK(ACLK), .ARESETN(ARESETN), .cfg_enable(cfg_enable),
      .radio_rst_n(radio_rst_n), .radio_en(radio_en),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
      .seq_state(seq_state), .pass_cnt(pass_cnt)
   );

   always #5 ACLK = ~ACLK;

   typedef struct {
      int unsigned cyc;
      logic [7:0]  cfg;
      logic        tvalid;
      logic        tlast;
      logic        mready;
      logic [2:0]  st;
      logic        rst_n;
      logic        en;
      logic        s_rdy;
      logic        m_vld;
   } vec_t;

   vec_t tbl[11];

   int n_vec = 0;
   int n_err = 0;

   // Radio source model and stream bookkeeping
   logic [15:0] pkt_no, beat_no, first_fwd_beat;
   logic        src_valid, dst_ready, last_fwd_tlast;
   logic [31:0] exp_next;
   bit          sb_on, chk_ready, fwd_seen;
   int          fwd_cnt, drop_cnt, fwd_since_rst, bu_rst_low;
   logic [2:0]  bu_trace[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: drive source, sample mid-cycle, advance source on handshake.
   task automatic tick();
      logic s_hs, m_hs;
      s_axis_tdata  = {pkt_no, beat_no};
      s_axis_tvalid = src_valid;
      s_axis_tlast  = (beat_no == 16'(PKT_LEN - 1));
      m_axis_tready = dst_ready;
      #3;
      s_hs = s_axis_tvalid & s_axis_tready;
      m_hs = m_axis_tvalid & m_axis_tready;
      if (chk_ready) chk("tready_follow", 32'(s_axis_tready), 32'(dst_ready));
      if (m_hs) begin
         chk("fwd_data", m_axis_tdata, {pkt_no, beat_no});
         chk("fwd_last", 32'(m_axis_tlast), 32'(beat_no == 16'(PKT_LEN - 1)));
         if (sb_on) begin
            chk("sb_order", m_axis_tdata, exp_next);
            if (exp_next[15:0] == 16'(PKT_LEN - 1)) exp_next = {exp_next[31:16] + 16'd1, 16'd0};
            else exp_next = exp_next + 32'd1;
         end
         if (!fwd_seen) begin
            fwd_seen       = 1'b1;
            first_fwd_beat = beat_no;
         end
         fwd_cnt++;
         fwd_since_rst++;
         last_fwd_tlast = s_axis_tlast;
      end
      if (s_hs && !m_hs) drop_cnt++;
      @(posedge ACLK);
      #1;
      if (s_hs) begin
         if (beat_no == 16'(PKT_LEN - 1)) begin
            pkt_no++;
            beat_no = 16'd0;
         end else begin
            beat_no++;
         end
      end
      // A radio held in reset restarts at a packet boundary.
      if (!radio_rst_n && beat_no != 16'd0) begin
         pkt_no++;
         beat_no = 16'd0;
      end
   endtask

   task automatic bring_up();
      logic [2:0] prev;
      prev = seq_state;
      bu_trace.delete();
      bu_rst_low = 0;
      drop_cnt   = 0;
      fwd_seen   = 1'b0;
      for (int n = 0; n < 3000 && !fwd_seen; n++) begin
         tick();
         if (seq_state != prev) begin
            bu_trace.push_back(seq_state);
            prev = seq_state;
         end
         if (!radio_rst_n) bu_rst_low++;
      end
      chk("bringup_reached_fwd", 32'(fwd_seen), 32'd1);
   endtask

   task automatic tick_until_beat(input logic [15:0] b);
      for (int n = 0; n < 200 && beat_no != b; n++) tick();
      chk("reach_beat", 32'(beat_no), 32'(b));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit saw_drain;
      int exp_fwd, low_cnt;

      //           cyc cfg    vld   lst   mrdy  state     rst_n en    s_rdy m_vld
      tbl[0]  = '{3,  8'h00, 1'b1, 1'b0, 1'b1, S_OFF,    1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{2,  8'hFC, 1'b1, 1'b0, 1'b1, S_OFF,    1'b0, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{16, 8'h01, 1'b0, 1'b0, 1'b1, S_RESET,  1'b0, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{1,  8'h00, 1'b0, 1'b0, 1'b1, S_OFF,    1'b0, 1'b0, 1'b0, 1'b0};
      tbl[4]  = '{1,  8'h02, 1'b0, 1'b0, 1'b1, S_RESET,  1'b0, 1'b0, 1'b0, 1'b0};
      tbl[5]  = '{10, 8'h03, 1'b1, 1'b0, 1'b1, S_RESET,  1'b0, 1'b0, 1'b0, 1'b0};
      tbl[6]  = '{15, 8'h01, 1'b0, 1'b0, 1'b1, S_RESET,  1'b0, 1'b0, 1'b0, 1'b0};
      tbl[7]  = '{1,  8'h01, 1'b0, 1'b0, 1'b1, S_WARMUP, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[8]  = '{3,  8'h01, 1'b1, 1'b0, 1'b0, S_WARMUP, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[9]  = '{1,  8'h01, 1'b1, 1'b1, 1'b1, S_WARMUP, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[10] = '{1,  8'h00, 1'b0, 1'b0, 1'b1, S_OFF,    1'b0, 1'b0, 1'b0, 1'b0};

      ARESETN       = 1'b0;
      cfg_enable    = 8'h00;
      s_axis_tdata  = '0;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      m_axis_tready = 1'b0;
      pkt_no = 16'd0; beat_no = 16'd0; first_fwd_beat = 16'd0;
      src_valid = 1'b1; dst_ready = 1'b1; last_fwd_tlast = 1'b0;
      exp_next = 32'd0; sb_on = 1'b0; chk_ready = 1'b0; fwd_seen = 1'b0;
      fwd_cnt = 0; drop_cnt = 0; fwd_since_rst = 0; bu_rst_low = 0;

      repeat (2) @(posedge ACLK);
      #1;
      chk("rst_state", 32'(seq_state), 32'(S_OFF));
      chk("rst_radio_rst_n", 32'(radio_rst_n), 32'd0);
      chk("rst_radio_en", 32'(radio_en), 32'd0);
      chk("rst_s_tready", 32'(s_axis_tready), 32'd0);
      chk("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
      chk("rst_pass_cnt", pass_cnt, 32'd0);
      ARESETN = 1'b1;

      // Sequencing and gating vectors
      for (int r = 0; r < 11; r++) begin
         for (int c = 0; c < int'(tbl[r].cyc); c++) begin
            cfg_enable    = tbl[r].cfg;
            s_axis_tdata  = 32'hDEAD_BEEF;
            s_axis_tvalid = tbl[r].tvalid;
            s_axis_tlast  = tbl[r].tlast;
            m_axis_tready = tbl[r].mready;
            @(posedge ACLK);
            #1;
            chk($sformatf("tbl%0d_state", r), 32'(seq_state), 32'(tbl[r].st));
            chk($sformatf("tbl%0d_rst_n", r), 32'(radio_rst_n), 32'(tbl[r].rst_n));
            chk($sformatf("tbl%0d_en", r), 32'(radio_en), 32'(tbl[r].en));
            chk($sformatf("tbl%0d_s_tready", r), 32'(s_axis_tready), 32'(tbl[r].s_rdy));
            chk($sformatf("tbl%0d_m_tvalid", r), 32'(m_axis_tvalid), 32'(tbl[r].m_vld));
            chk($sformatf("tbl%0d_m_tdata_gated", r), m_axis_tdata, 32'd0);
            chk($sformatf("tbl%0d_m_tlast_gated", r), 32'(m_axis_tlast), 32'd0);
         end
      end

      // Bring-up from OFF: reset length, warmup discard, packet-aligned start
      pkt_no = 16'd0; beat_no = 16'd0;
      cfg_enable = 8'h01;
      bring_up();
      chk("t1_rst_low_cycles", 32'(bu_rst_low), 32'(RST_CYCLES));
      chk("t1_dropped_beats", 32'(drop_cnt), 32'(WARMUP_BEATS));
      chk("t1_first_fwd_beat", 32'(first_fwd_beat), 32'd0);
      chk("t1_trace_len", 32'(bu_trace.size()), 32'd3);
      if (bu_trace.size() == 3) begin
         chk("t1_trace0", 32'(bu_trace[0]), 32'(S_RESET));
         chk("t1_trace1", 32'(bu_trace[1]), 32'(S_WARMUP));
         chk("t1_trace2", 32'(bu_trace[2]), 32'(S_RUN));
      end
      chk("t1_radio_en", 32'(radio_en), 32'd1);

      // RUN dropped at beat 10 of a packet: drain to tlast
      tick_until_beat(16'd9);
      cfg_enable = 8'h00;
      fwd_cnt = 0; saw_drain = 1'b0; last_fwd_tlast = 1'b0;
      for (int n = 0; n < 200; n++) begin
         tick();
         if (seq_state == S_DRAIN) saw_drain = 1'b1;
         if (seq_state == S_OFF) break;
      end
      chk("t2_saw_drain", 32'(saw_drain), 32'd1);
      chk("t2_state_off", 32'(seq_state), 32'(S_OFF));
      chk("t2_fwd_beats", 32'(fwd_cnt), 32'(PKT_LEN - 9));
      chk("t2_last_was_tlast", 32'(last_fwd_tlast), 32'd1);
      chk("t2_radio_en", 32'(radio_en), 32'd0);
      chk("t2_radio_rst_n", 32'(radio_rst_n), 32'd0);

      // RUN dropped together with a tlast handshake: straight to OFF
      cfg_enable = 8'h01;
      bring_up();
      chk("t3_state_run", 32'(seq_state), 32'(S_RUN));
      tick_until_beat(16'(PKT_LEN - 1));
      cfg_enable = 8'h00;
      fwd_cnt = 0; last_fwd_tlast = 1'b0;
      tick();
      chk("t3_tlast_fwd", 32'(fwd_cnt), 32'd1);
      chk("t3_last_was_tlast", 32'(last_fwd_tlast), 32'd1);
      chk("t3_direct_off", 32'(seq_state), 32'(S_OFF));

      // Backpressure and source gaps in RUN: ordered, lossless passthrough
      cfg_enable = 8'h01;
      bring_up();
      sb_on = 1'b1; chk_ready = 1'b1;
      exp_next = {pkt_no, beat_no};
      fwd_cnt = 0; exp_fwd = 0;
      for (int i = 0; i < 200; i++) begin
         dst_ready = (i % 2) == 1;
         src_valid = (i % 5) != 4;
         if (dst_ready && src_valid) exp_fwd++;
         tick();
      end
      sb_on = 1'b0; chk_ready = 1'b0;
      dst_ready = 1'b1; src_valid = 1'b1;
      chk("t4_fwd_count", 32'(fwd_cnt), 32'(exp_fwd));
      chk("t4_state_run", 32'(seq_state), 32'(S_RUN));

      // FORCE_RST pulse mid-packet in RUN
      tick_until_beat(16'd20);
      cfg_enable = 8'h03;
      tick();
      fwd_since_rst = 0;
      chk("t5_reset_next", 32'(seq_state), 32'(S_RESET));
      low_cnt = radio_rst_n ? 0 : 1;
      for (int i = 1; i < int'(FORCE_LEN); i++) begin
         tick();
         if (!radio_rst_n) low_cnt++;
      end
      cfg_enable = 8'h01;
      for (int n = 0; n < 100 && seq_state == S_RESET; n++) begin
         tick();
         if (!radio_rst_n) low_cnt++;
      end
      // Forced cycles after the first overlap the held timer; RST_CYCLES more follow release.
      chk("t5_rst_low_cycles", 32'(low_cnt), 32'(FORCE_LEN - 1 + RST_CYCLES));
      chk("t5_warmup", 32'(seq_state), 32'(S_WARMUP));
      bring_up();
      chk("t5_back_to_run", 32'(seq_state), 32'(S_RUN));
      chk("t5_first_fwd_beat", 32'(first_fwd_beat), 32'd0);
      chk("t5_dropped_beats", 32'(drop_cnt), 32'(WARMUP_BEATS));

      // pass_cnt after 300 forwarded beats, then async reset mid-DRAIN
      for (int n = 0; n < 400 && fwd_since_rst < 300; n++) tick();
      chk("t6_pass_cnt_300", pass_cnt, EXP_PASS_300);
      tick_until_beat(16'd5);
      cfg_enable = 8'h00;
      tick();
      chk("t6_in_drain", 32'(seq_state), 32'(S_DRAIN));
      #2;
      ARESETN = 1'b0;
      #1;
      chk("t6_async_state", 32'(seq_state), 32'(S_OFF));
      chk("t6_async_rst_n", 32'(radio_rst_n), 32'd0);
      chk("t6_async_en", 32'(radio_en), 32'd0);
      chk("t6_async_s_tready", 32'(s_axis_tready), 32'd0);
      chk("t6_async_m_tvalid", 32'(m_axis_tvalid), 32'd0);
      chk("t6_async_m_tdata", m_axis_tdata, 32'd0);
      chk("t6_async_m_tlast", 32'(m_axis_tlast), 32'd0);
      chk("t6_async_pass_cnt", pass_cnt, 32'd0);
      repeat (2) @(posedge ACLK);
      #1;
      ARESETN = 1'b1;
      tick();
      chk("t6_stays_off", 32'(seq_state), 32'(S_OFF));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
